// File: rtl/azadi_wb_mgmt_mailbox_if.sv
// Wishbone classic bus between the Caravel management core and the Azadi
// management mailbox. The master modport is the management core side.
interface azadi_wb_mgmt_mailbox_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/azadi_wb_mgmt_mailbox.sv
// Wishbone responder giving the management core control of the Azadi SoC:
// CTRL/CPB/STATUS registers plus a management-to-SoC mailbox FIFO.
module azadi_wb_mgmt_mailbox #(
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter logic [15:0] CPB_RESET  = 16'd868,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    azadi_wb_mgmt_mailbox_if.slave        wbs,
    output logic                          soc_rst_req_o,
    output logic                          prog_ovr_o,
    output logic                          prog_val_o,
    output logic [15:0]                   clks_per_bit_o,
    output logic [31:0]                   mbox_data_o,
    output logic                          mbox_valid_o,
    input  logic                          mbox_ready_i
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    localparam logic [5:0] OFF_CTRL   = 6'h00;
    localparam logic [5:0] OFF_CPB    = 6'h01;
    localparam logic [5:0] OFF_MBOX   = 6'h02;
    localparam logic [5:0] OFF_STATUS = 6'h03;

    logic          ack_p1;
    logic [31:0]   rdata_p1;
    logic [2:0]    ctrl;
    logic [15:0]   cpb;
    logic [31:0]   mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [4:0]    count5;
    logic          overflow;

    logic          req, hit, wr;
    logic [5:0]    off;
    logic          full, empty;
    logic          push, pop, push_ok, ovf_set, ovf_clr;
    logic [31:0]   rdata;
    logic          unused_adr;

    // ack is registered, so masking req with it yields the ack/idle cadence
    assign req     = wbs.wbs_cyc_i & wbs.wbs_stb_i & ~ack_p1;
    assign hit     = req & (wbs.wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign off     = wbs.wbs_adr_i[7:2];
    assign wr      = hit & wbs.wbs_we_i;
    assign unused_adr = ^wbs.wbs_adr_i[1:0];

    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign count5  = 5'(count);
    assign push    = wr & (off == OFF_MBOX) & (wbs.wbs_sel_i == 4'hF);
    assign pop     = ~empty & mbox_ready_i;
    // A pop in the same cycle frees the slot, so a push on full still lands
    assign push_ok = push & (~full | pop);
    assign ovf_set = push & full & ~pop;
    assign ovf_clr = wr & (off == OFF_STATUS) & wbs.wbs_sel_i[1] & wbs.wbs_dat_i[10];

    always_comb begin
        rdata = '0;
        if (hit && !wbs.wbs_we_i) begin
            case (off)
                OFF_CTRL:   rdata = {29'd0, ctrl};
                OFF_CPB:    rdata = {16'd0, cpb};
                OFF_MBOX:   rdata = empty ? 32'd0 : mem[rd_ptr];
                OFF_STATUS: rdata = {21'd0, overflow, empty, full, 3'd0, count5};
                default:    rdata = '0;
            endcase
        end
    end

    // Stage p1: bus response, register and FIFO state commit on the ack edge
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ack_p1   <= 1'b0;
            rdata_p1 <= '0;
            ctrl     <= '0;
            cpb      <= CPB_RESET;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            ack_p1   <= req;
            rdata_p1 <= rdata;
            if (wr && off == OFF_CTRL && wbs.wbs_sel_i[0]) begin
                ctrl <= wbs.wbs_dat_i[2:0];
            end
            if (wr && off == OFF_CPB) begin
                if (wbs.wbs_sel_i[0]) cpb[7:0]  <= wbs.wbs_dat_i[7:0];
                if (wbs.wbs_sel_i[1]) cpb[15:8] <= wbs.wbs_dat_i[15:8];
            end
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop)     rd_ptr <= rd_ptr + PW'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (ovf_set)      overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
        end
    end

    // Storage is data only; the pointers and count define what is valid
    always_ff @(posedge clk_i) begin
        if (push_ok) mem[wr_ptr] <= wbs.wbs_dat_i;
    end

    assign wbs.wbs_ack_o = ack_p1;
    assign wbs.wbs_dat_o = rdata_p1;
    assign soc_rst_req_o = ctrl[0];
    assign prog_ovr_o    = ctrl[1];
    assign prog_val_o    = ctrl[2];
    assign clks_per_bit_o = cpb;
    assign mbox_data_o   = mem[rd_ptr];
    assign mbox_valid_o  = ~empty;
endmodule

// File: tb/tb_azadi_wb_mgmt_mailbox.sv
// Directed bench for azadi_wb_mgmt_mailbox: register access, mailbox fill,
// overflow, simultaneous push/pop, unmapped/miss accesses and reset.
module tb_azadi_wb_mgmt_mailbox;
    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        soc_rst_req, prog_ovr, prog_val;
    logic [15:0] cpb;
    logic [31:0] mbox_data;
    logic        mbox_valid;
    logic        mbox_ready = 1'b0;

    int errors = 0;
    int checks = 0;
    logic [31:0] rd_q[$];
    logic [31:0] mbox_q[$];

    azadi_wb_mgmt_mailbox_if bus ();

    azadi_wb_mgmt_mailbox dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .wbs            (bus),
        .soc_rst_req_o  (soc_rst_req),
        .prog_ovr_o     (prog_ovr),
        .prog_val_o     (prog_val),
        .clks_per_bit_o (cpb),
        .mbox_data_o    (mbox_data),
        .mbox_valid_o   (mbox_valid),
        .mbox_ready_i   (mbox_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic bus_idle();
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_sel_i = 4'h0;
        bus.wbs_adr_i = 32'h0;
        bus.wbs_dat_i = 32'h0;
    endtask

    task automatic bus_cycle(input string tag, input logic we, input logic [31:0] adr,
                             input logic [3:0] sel, input logic [31:0] wdat, input logic rdy);
        int lat;
        logic [31:0] exp;
        @(negedge clk);
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_we_i  = we;
        bus.wbs_adr_i = adr;
        bus.wbs_sel_i = sel;
        bus.wbs_dat_i = wdat;
        mbox_ready    = rdy;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!bus.wbs_ack_o && lat < 4);
        check({tag, "_ack_latency"}, 32'(lat), 32'd1);
        if (!we) begin
            exp = (rd_q.size() > 0) ? rd_q.pop_front() : 32'hDEAD_BEEF;
            check({tag, "_rdata"}, bus.wbs_dat_o, exp);
        end
        bus_idle();
        mbox_ready = 1'b0;
        @(posedge clk);
        #1;
        check({tag, "_post_ack"}, {bus.wbs_ack_o, bus.wbs_dat_o[30:0]}, 32'h0);
    endtask

    task automatic rd(input string tag, input logic [31:0] adr, input logic [31:0] exp);
        rd_q.push_back(exp);
        bus_cycle(tag, 1'b0, adr, 4'hF, 32'h0, 1'b0);
    endtask

    task automatic wr(input string tag, input logic [31:0] adr, input logic [3:0] sel,
                      input logic [31:0] dat, input logic rdy);
        bus_cycle(tag, 1'b1, adr, sel, dat, rdy);
    endtask

    task automatic soc_pop(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("pop_valid", 32'(mbox_valid), 32'd1);
            check("pop_data", mbox_data, (mbox_q.size() > 0) ? mbox_q.pop_front() : 32'hDEAD_BEEF);
            mbox_ready = 1'b1;
            @(posedge clk);
            #1;
            mbox_ready = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acks;
        bus_idle();

        // Asynchronous reset before any clock edge
        #1 rst_n = 1'b0;
        #2;
        check("rst_ack", 32'(bus.wbs_ack_o), 32'd0);
        check("rst_dat", bus.wbs_dat_o, 32'h0);
        check("rst_ctrl", {29'd0, prog_val, prog_ovr, soc_rst_req}, 32'h0);
        check("rst_cpb", 32'(cpb), 32'd868);
        check("rst_valid", 32'(mbox_valid), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Register access
        wr("cpb_wr", BASE + 32'h4, 4'b0001, 32'h0000_01B2, 1'b0);
        check("cpb_out", 32'(cpb), 32'h03B2);
        wr("ctrl_wr", BASE, 4'hF, 32'h5, 1'b0);
        check("ctrl_out", {29'd0, prog_val, prog_ovr, soc_rst_req}, 32'h5);
        wr("ctrl_nosel", BASE, 4'b1110, 32'h0, 1'b0);
        check("ctrl_nosel_out", {29'd0, prog_val, prog_ovr, soc_rst_req}, 32'h5);
        rd("cpb_rd", BASE + 32'h4, 32'h03B2);
        rd("ctrl_rd", BASE, 32'h5);

        // Fill and overflow
        rd("status_empty", BASE + 32'hC, 32'h0000_0200);
        for (int i = 0; i < 5; i++) begin
            wr("push", BASE + 32'h8, 4'hF, 32'hA0 + 32'(i), 1'b0);
            if (i < 4) mbox_q.push_back(32'hA0 + 32'(i));
        end
        rd("status_ovf", BASE + 32'hC, 32'h0000_0504);
        rd("mbox_head_rd", BASE + 32'h8, 32'hA0);
        soc_pop(4);
        @(negedge clk);
        check("drained_valid", 32'(mbox_valid), 32'd0);
        rd("mbox_empty_rd", BASE + 32'h8, 32'h0);
        rd("status_drained", BASE + 32'hC, 32'h0000_0600);
        wr("ovf_clr", BASE + 32'hC, 4'b0010, 32'h400, 1'b0);
        rd("status_clr", BASE + 32'hC, 32'h0000_0200);
        wr("push_partial_sel", BASE + 32'h8, 4'h7, 32'hEE, 1'b0);
        rd("status_partial", BASE + 32'hC, 32'h0000_0200);

        // Simultaneous push and pop on a full FIFO
        for (int i = 0; i < 4; i++) begin
            wr("fill", BASE + 32'h8, 4'hF, 32'hC0 + 32'(i), 1'b0);
            mbox_q.push_back(32'hC0 + 32'(i));
        end
        @(negedge clk);
        check("full_head", mbox_data, mbox_q.pop_front());
        wr("push_pop_full", BASE + 32'h8, 4'hF, 32'hBB, 1'b1);
        mbox_q.push_back(32'hBB);
        rd("status_push_pop", BASE + 32'hC, 32'h0000_0104);
        soc_pop(4);
        rd("status_after_bb", BASE + 32'hC, 32'h0000_0200);

        // Unmapped offset and window miss
        rd("unmapped_rd", BASE + 32'h40, 32'h0);
        rd("miss_rd", 32'h3100_0000, 32'h0);
        wr("miss_wr", 32'h3100_0000, 4'hF, 32'hFFFF_FFFF, 1'b0);
        check("miss_ctrl", {29'd0, prog_val, prog_ovr, soc_rst_req}, 32'h5);
        check("miss_cpb", 32'(cpb), 32'h03B2);

        // Strobe held for 6 cycles gives ack, idle, ack, ...
        @(negedge clk);
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_we_i  = 1'b1;
        bus.wbs_adr_i = BASE + 32'h8;
        bus.wbs_sel_i = 4'hF;
        bus.wbs_dat_i = 32'hD0;
        acks = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (bus.wbs_ack_o) begin
                acks++;
                mbox_q.push_back(32'hD0);
            end
        end
        bus_idle();
        check("b2b_acks", 32'(acks), 32'd3);
        rd("status_b2b", BASE + 32'hC, 32'h0000_0003);

        // Reset mid-transaction drops the pending ack and flushes the FIFO
        @(negedge clk);
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_adr_i = BASE;
        bus.wbs_sel_i = 4'hF;
        @(posedge clk);
        #1;
        check("pre_rst_ack", 32'(bus.wbs_ack_o), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_ack", 32'(bus.wbs_ack_o), 32'd0);
        check("mid_rst_dat", bus.wbs_dat_o, 32'h0);
        check("mid_rst_valid", 32'(mbox_valid), 32'd0);
        check("mid_rst_ctrl", {29'd0, prog_val, prog_ovr, soc_rst_req}, 32'h0);
        check("mid_rst_cpb", 32'(cpb), 32'd868);
        bus_idle();
        mbox_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        rd("status_post_rst", BASE + 32'hC, 32'h0000_0200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/azadi_wb_mgmt_mailbox.md
# azadi_wb_mgmt_mailbox

Wishbone classic responder that lets the Caravel management core (the Wishbone initiator) control the Azadi SoC. It holds a control register, the UART clocks-per-bit value and a status register, plus a 4-entry, 32-bit mailbox FIFO that carries words from the management core to the SoC. It sits in the user-project wrapper on the `wbs_*` port group, between the management bus and `azadi_soc_top`.

## Interface
- `BASE_ADDR`, default `32'h3000_0000` – window base; the block decodes `wbs_adr_i[31:8]` against `BASE_ADDR[31:8]`.
- `CPB_RESET`, default `16'd868` – reset value of `clks_per_bit_o`.
- `FIFO_DEPTH`, default `4` – mailbox depth; must be a power of two, 2..16.

Ports:
- `clk_i` – in – 1 – single clock (connected to `wb_clk_i`).
- `rst_ni` – in – 1 – reset, asynchronous assert, active-low.
- `wbs_stb_i`, `wbs_cyc_i`, `wbs_we_i` – in – 1 each – Wishbone strobe, cycle and write enable.
- `wbs_sel_i` – in – 4 – byte selects.
- `wbs_adr_i`, `wbs_dat_i` – in – 32 each – address and write data.
- `wbs_ack_o` – out – 1 – acknowledge.
- `wbs_dat_o` – out – 32 – read data.
- `soc_rst_req_o` – out – 1 – holds the SoC in reset while high.
- `prog_ovr_o`, `prog_val_o` – out – 1 each – override enable and override value for the prog pin.
- `clks_per_bit_o` – out – 16 – UART baud divisor.
- `mbox_data_o` – out – 32 – head of the mailbox FIFO.
- `mbox_valid_o` – out – 1 – FIFO not empty.
- `mbox_ready_i` – in – 1 – SoC pops the FIFO.

## Operation
A request is `req = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o`. A hit is `req` with `wbs_adr_i[31:8] == BASE_ADDR[31:8]`. Registers are selected by `wbs_adr_i[7:2]`:

- **0x00 CTRL**, RW:
  - bit0 `soc_rst_req`, bit1 `prog_ovr`, bit2 `prog_val`.
  - Bits 31:3 read 0.
  - A write takes effect only if `sel[0]` is set.
- **0x04 CPB**, RW:
  - bits 15:0 hold the divisor; `sel[0]` writes [7:0] and `sel[1]` writes [15:8].
  - Bits 31:16 read 0.
- **0x08 MBOX**:
  - Write with `sel == 4'hF` pushes `wbs_dat_i`. A write with any other `sel` is ignored but still acked.
  - Read returns the FIFO head, or 0 when empty. A read never pops.
- **0x0C STATUS**:
  - [4:0] count (0..FIFO_DEPTH), bit8 full, bit9 empty, bit10 overflow (sticky).
  - Writing 1 to bit10 with `sel[1]` set clears overflow. Other bits are read-only.
- **Other offsets in the window, and any miss**: acked. A read returns `32'h0`; a write has no effect. The bus never hangs.

Mailbox FIFO:
- Circular buffer with read and write pointers that wrap modulo FIFO_DEPTH, and a separate count.
- Push when full: the data is dropped and overflow is set in the same cycle.
- Pop happens when `mbox_valid_o & mbox_ready_i`. The SoC's `mbox_ready_i` while empty is ignored.
- Push and pop in the same cycle: both are performed and count is unchanged. This applies when full too: the push is accepted, no overflow is set, and the pop frees the slot.
- `mbox_data_o` is the head entry; it is undefined-but-stable when `mbox_valid_o = 0`, and the bench must not check it then.

Reset values:
- `wbs_ack_o = 0`, `wbs_dat_o = 0`.
- CTRL = 0, so `soc_rst_req_o = 0`, `prog_ovr_o = 0`, `prog_val_o = 0`.
- `clks_per_bit_o = CPB_RESET`.
- FIFO empty: `mbox_valid_o = 0`, count = 0, overflow = 0.
- Reset mid-transaction drops any pending ack immediately and flushes the FIFO.

## Timing
- Ack latency is 1: `req` in cycle N gives `wbs_ack_o = 1` in cycle N+1, for exactly one cycle.
- With `stb` held continuously, transfers occur on every second cycle (ack, idle, ack, ...).
- Register writes, FIFO pushes and overflow updates commit on the clock edge that asserts ack. New values are visible on outputs in cycle N+1.
- `wbs_dat_o` is registered and valid in the ack cycle. It samples state at edge N, so a read of STATUS in the same cycle as a SoC pop returns the pre-pop count.
- `wbs_dat_o` returns to 0 the cycle after ack.
- Pop to `mbox_valid_o` / `mbox_data_o` update: 1 cycle, registered pointers.
- Push to `mbox_valid_o` rising: 1 cycle after the ack edge.
- If `wbs_stb_i` drops during the ack cycle, the access is still completed; there is no abort.

## Test plan
- **Reset**: drive `rst_ni = 0` mid-clock. All outputs take their reset values without waiting for a clock edge; `clks_per_bit_o = 868` and `mbox_valid_o = 0`.
- **Register access**: write CPB `0x0000_01B2` with `sel = 4'b0001`, giving `clks_per_bit_o = 0x03B2` (high byte from 868, `0x0364`). Then write CTRL `0x5`, giving `soc_rst_req_o = 1` and `prog_val_o = 1`. Reads return `0x03B2` and `0x5`, each acked exactly 1 cycle after `stb`.
- **FIFO fill and overflow**: push `0xA0`..`0xA4` (5 words) with `mbox_ready_i = 0`. STATUS reads `0x0000_0504` (count 4, full, overflow). The SoC then pops 4 words in order `0xA0`..`0xA3`, after which `mbox_valid_o = 0` and STATUS reads `0x0000_0600`. Writing `0x400` clears overflow.
- **Simultaneous push and pop on full FIFO**: fill with 4 words, then push `0xBB` with `mbox_ready_i = 1` in the commit cycle. The count stays 4, there is no overflow, and `0xBB` pops last.
- **Unmapped and miss**: a read of offset `0x40` and a read of address `0x3100_0000` are both acked in 1 cycle with data 0. A write to `0x3100_0000` changes no register.
- **Back-to-back strobe**: hold `stb` high for 6 cycles with `we = 1` to MBOX. Exactly 3 acks occur, 3 words are pushed, and count = 3.
